fft_mag_peak: RTL and testbench

//  Streaming magnitude stage between FFT_Control output and FIFO_Control input.

---
 rtl/fft_mag_pkg.sv | 19 +
 rtl/fft_mag_peak_mag_sq_pipe.sv | 48 ++++
 rtl/fft_mag_peak.sv | 99 +++++++++
 tb/tb_fft_mag_peak.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_mag_pkg.sv
// rtl/fft_mag_pkg.sv - shared widths, pipeline latency and saturation helper for fft_mag_peak
package fft_mag_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_MAG_W  = 32;
    localparam int DEF_IDX_W  = 16;
    localparam int DEF_NFFT   = 1024;
    localparam int LATENCY    = 3;
    localparam int SAT_W      = 128;

    // Clamp to the largest value representable in mag_w bits; callers narrow the result.
    function automatic logic [SAT_W-1:0] saturate(input logic [SAT_W-1:0] value,
                                                  input int unsigned mag_w);
        logic [SAT_W-1:0] max_val;
        max_val = (mag_w >= SAT_W) ? '1 : ((SAT_W'(1) << mag_w) - SAT_W'(1));
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/fft_mag_peak_mag_sq_pipe.sv
// rtl/fft_mag_peak_mag_sq_pipe.sv - three-stage |re|,|im| -> squares -> shifted saturated sum
module mag_sq_pipe
    import fft_mag_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAG_W  = DEF_MAG_W,
    parameter int SHIFT  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] re,
    input  logic signed [DATA_W-1:0] im,
    input  logic                     valid,
    output logic [MAG_W-1:0]         mag,
    output logic                     mag_valid
);

    logic [DATA_W-1:0]   abs_re, abs_im;
    logic [2*DATA_W-1:0] sq_re, sq_im, sum, scaled;
    logic                v1, v2;

    assign sum    = sq_re + sq_im;
    assign scaled = sum >> SHIFT;

    // Data registers run freely; only the valid chain decides what is a real beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs_re    <= '0;
            abs_im    <= '0;
            sq_re     <= '0;
            sq_im     <= '0;
            mag       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            mag_valid <= 1'b0;
        end else begin
            abs_re    <= re[DATA_W-1] ? DATA_W'(-re) : DATA_W'(re);
            abs_im    <= im[DATA_W-1] ? DATA_W'(-im) : DATA_W'(im);
            sq_re     <= (2*DATA_W)'(abs_re) * (2*DATA_W)'(abs_re);
            sq_im     <= (2*DATA_W)'(abs_im) * (2*DATA_W)'(abs_im);
            mag       <= MAG_W'(saturate(SAT_W'(scaled), MAG_W));
            v1        <= valid;
            v2        <= v1;
            mag_valid <= v2;
        end
    end

endmodule

// File: rtl/fft_mag_peak.sv
// rtl/fft_mag_peak.sv - streaming squared-magnitude stage with optional per-frame peak tracker
// Define FFT_PEAK_DETECT_EN to build the peak tracker; otherwise peak_* are tied to 0.
module fft_mag_peak
    import fft_mag_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAG_W  = DEF_MAG_W,
    parameter int SHIFT  = 32,
    parameter int NFFT   = DEF_NFFT,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] data_re,
    input  logic signed [DATA_W-1:0] data_im,
    input  logic                     data_valid,
    input  logic [IDX_W-1:0]         data_index,
    output logic [MAG_W-1:0]         mag_out,
    output logic                     mag_valid,
    output logic [IDX_W-1:0]         mag_index,
    output logic                     mag_last,
    output logic [MAG_W-1:0]         peak_mag,
    output logic [IDX_W-1:0]         peak_index,
    output logic                     peak_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);

    logic [IDX_W-1:0]   idx_pipe [LATENCY];
    logic [LATENCY-1:0] last_pipe;

    mag_sq_pipe #(
        .DATA_W (DATA_W),
        .MAG_W  (MAG_W),
        .SHIFT  (SHIFT)
    ) u_mag_sq_pipe (
        .clk       (clk),
        .rst       (rst),
        .re        (data_re),
        .im        (data_im),
        .valid     (data_valid),
        .mag       (mag_out),
        .mag_valid (mag_valid)
    );

    // Last flag is qualified at entry so it can only ever ride with a valid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) idx_pipe[i] <= '0;
            last_pipe <= '0;
        end else begin
            idx_pipe[0]  <= data_index;
            last_pipe[0] <= data_valid && (data_index == LAST_IDX);
            for (int i = 1; i < LATENCY; i++) begin
                idx_pipe[i]  <= idx_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign mag_index = idx_pipe[LATENCY-1];
    assign mag_last  = last_pipe[LATENCY-1];

`ifdef FFT_PEAK_DETECT_EN
    logic [MAG_W-1:0] cur_max, win_mag;
    logic [IDX_W-1:0] cur_idx, win_idx;
    logic             take;

    // Bin 0 restarts the frame; strict compare keeps the earliest bin on ties.
    assign take    = (mag_index == '0) || (mag_out > cur_max);
    assign win_mag = take ? mag_out : cur_max;
    assign win_idx = take ? mag_index : cur_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_max    <= '0;
            cur_idx    <= '0;
            peak_mag   <= '0;
            peak_index <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= mag_last;
            if (mag_valid) begin
                cur_max <= win_mag;
                cur_idx <= win_idx;
            end
            if (mag_last) begin
                peak_mag   <= win_mag;
                peak_index <= win_idx;
            end
        end
    end
`else
    assign peak_mag   = '0;
    assign peak_index = '0;
    assign peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fft_mag_peak.sv
// tb/tb_fft_mag_peak.sv - randomized self-checking bench for fft_mag_peak (SHIFT=0 and SHIFT=32, NFFT=8)
module tb_fft_mag_peak;

    typedef struct packed {
        logic [31:0] m0;
        logic [31:0] m1;
        logic [15:0] idx;
        logic        last;
        logic [31:0] cyc;
    } beat_t;

    typedef struct packed {
        logic [31:0] m0;
        logic [15:0] i0;
        logic [31:0] m1;
        logic [15:0] i1;
        logic [31:0] cyc;
    } pk_t;

    logic               clk;
    logic               rst;
    logic signed [31:0] re, im;
    logic               valid;
    logic [15:0]        index;

    logic [31:0] mag_out0, mag_out1, peak_mag0, peak_mag1;
    logic [15:0] mag_index0, mag_index1, peak_index0, peak_index1;
    logic        mag_valid0, mag_valid1, mag_last0, mag_last1, peak_valid0, peak_valid1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int side_err = 0;
    int pk_nz = 0;
    bit fstart = 0;

    beat_t exp_q[$], obs_q[$], fq[$];
    pk_t   exp_pk[$], obs_pk[$];

    fft_mag_peak #(.SHIFT(0), .NFFT(8)) dut0 (
        .clk(clk), .rst(rst), .data_re(re), .data_im(im), .data_valid(valid), .data_index(index),
        .mag_out(mag_out0), .mag_valid(mag_valid0), .mag_index(mag_index0), .mag_last(mag_last0),
        .peak_mag(peak_mag0), .peak_index(peak_index0), .peak_valid(peak_valid0));

    fft_mag_peak #(.SHIFT(32), .NFFT(8)) dut1 (
        .clk(clk), .rst(rst), .data_re(re), .data_im(im), .data_valid(valid), .data_index(index),
        .mag_out(mag_out1), .mag_valid(mag_valid1), .mag_index(mag_index1), .mag_last(mag_last1),
        .peak_mag(peak_mag1), .peak_index(peak_index1), .peak_valid(peak_valid1));

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture only; the test tasks judge what was captured.
    always @(negedge clk) begin
        if (!rst) begin
            if (mag_valid0) obs_q.push_back({mag_out0, mag_out1, mag_index0, mag_last0, 32'(cyc)});
            if ((mag_valid0 !== mag_valid1) || (mag_index0 !== mag_index1) || (mag_last0 !== mag_last1)
                || (mag_last0 && !mag_valid0) || (peak_valid0 !== peak_valid1)) side_err++;
            if (peak_valid0) obs_pk.push_back({peak_mag0, peak_index0, peak_mag1, peak_index1, 32'(cyc)});
            if ((peak_mag0 | peak_mag1) != 0 || (peak_index0 | peak_index1) != 0) pk_nz++;
        end
    end

    function automatic logic [31:0] mag_ref(input logic signed [31:0] a, input logic signed [31:0] b,
                                            input int sh);
        logic signed [127:0] aa, bb;
        logic [127:0] s;
        aa = a;
        bb = b;
        s = 128'(aa * aa + bb * bb) >> sh;
        return (s > 128'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic clear_all();
        exp_q.delete(); obs_q.delete(); fq.delete(); exp_pk.delete(); obs_pk.delete();
        fstart = 0; side_err = 0; pk_nz = 0;
    endtask

    // Drive one cycle and record what the spec says must appear 3 (and 4) cycles later.
    task automatic drive(input logic signed [31:0] r, input logic signed [31:0] i, input logic v,
                         input logic [15:0] x);
        beat_t b;
        pk_t   p;
        int    k0;
        @(negedge clk);
        re = r; im = i; valid = v; index = x;
        if (v) begin
            b.m0 = mag_ref(r, i, 0); b.m1 = mag_ref(r, i, 32);
            b.idx = x; b.last = (x == 16'd7); b.cyc = 32'(cyc + 3);
            exp_q.push_back(b);
            if (x == 16'd0) begin fq.delete(); fstart = 1; end
            fq.push_back(b);
            if (b.last) begin
                p = '0; p.cyc = 32'(cyc + 4); k0 = 0;
                if (fstart) begin p.m0 = fq[0].m0; p.m1 = fq[0].m1; k0 = 1; end
                for (int k = k0; k < fq.size(); k++) begin
                    if (fq[k].m0 > p.m0) begin p.m0 = fq[k].m0; p.i0 = fq[k].idx; end
                    if (fq[k].m1 > p.m1) begin p.m1 = fq[k].m1; p.i1 = fq[k].idx; end
                end
`ifdef FFT_PEAK_DETECT_EN
                exp_pk.push_back(p);
`endif
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive($urandom, $urandom, 1'b0, 16'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; valid = 0;
        clear_all();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        valid = 1; index = 16'd7; re = 3; im = 4;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({mag_out0, mag_valid0, mag_index0, mag_last0, peak_mag0, peak_index0, peak_valid0} !== '0) begin
            n_fail++; $display("FAIL reset_dut0 got %h want 0",
                {mag_out0, mag_valid0, mag_index0, mag_last0, peak_mag0, peak_index0, peak_valid0});
        end
        n_chk++;
        if ({mag_out1, mag_valid1, mag_index1, mag_last1, peak_mag1, peak_index1, peak_valid1} !== '0) begin
            n_fail++; $display("FAIL reset_dut1 got %h want 0",
                {mag_out1, mag_valid1, mag_index1, mag_last1, peak_mag1, peak_index1, peak_valid1});
        end
        rst = 0; valid = 0;
        clear_all();
    endtask

    task automatic test_magnitude();
        logic signed [31:0] tre[5], tim[5];
        logic [15:0] tix[5];
        logic [31:0] te0[5], te1[5];
        tre = '{32'sd3, -32'sd3, 32'sh8000_0000, 32'sh0001_0000, 32'sh8000_0000};
        tim = '{32'sd4, -32'sd4, 32'sd0,         32'sh0001_0000, 32'sh8000_0000};
        tix = '{16'd5, 16'd6, 16'd2, 16'd3, 16'd4};
        te0 = '{32'd25, 32'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        te1 = '{32'd0, 32'd0, 32'h4000_0000, 32'd2, 32'h8000_0000};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); re = tre[k]; im = tim[k]; valid = 1; index = tix[k];
            @(negedge clk); valid = 0; re = $urandom; im = $urandom; index = 16'd7;
            @(negedge clk);
            n_chk++;
            if (mag_valid0 !== 1'b0) begin
                n_fail++; $display("FAIL mag_early case%0d got valid=%b want 0", k, mag_valid0);
            end
            @(negedge clk);
            n_chk++;
            if ({mag_valid0, mag_out0, mag_index0, mag_last0} !== {1'b1, te0[k], tix[k], 1'b0}) begin
                n_fail++; $display("FAIL mag_shift0 case%0d got v=%b mag=%h idx=%0d last=%b want mag=%h idx=%0d",
                    k, mag_valid0, mag_out0, mag_index0, mag_last0, te0[k], tix[k]);
            end
            n_chk++;
            if ({mag_valid1, mag_out1} !== {1'b1, te1[k]}) begin
                n_fail++; $display("FAIL mag_shift32 case%0d got v=%b mag=%h want %h", k, mag_valid1, mag_out1, te1[k]);
            end
        end
        idle(4);
        n_chk++;
        if (obs_pk.size() != 0 || side_err != 0) begin
            n_fail++; $display("FAIL mag_no_peak got peaks=%0d side_err=%0d want 0/0", obs_pk.size(), side_err);
        end
    endtask

    task automatic test_frame();
        int fre[8], fim[8];
        fre = '{1, 3, 0, 0, 1, 0, 2, 2};
        fim = '{0, 0, 2, -3, 1, 0, -1, 2};
        do_reset();
        for (int k = 0; k < 8; k++) drive(fre[k], fim[k], 1'b1, 16'(k));
        idle(6);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL frame beat_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            n_chk++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL frame beat%0d got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        n_chk++;
        if (obs_pk.size() != exp_pk.size() || side_err != 0) begin
            n_fail++; $display("FAIL frame peak_count got %0d side_err=%0d want %0d/0", obs_pk.size(), side_err, exp_pk.size());
        end
        foreach (exp_pk[k]) if (k < obs_pk.size()) begin
            n_chk++;
            if (obs_pk[k] !== exp_pk[k]) begin
                n_fail++; $display("FAIL frame peak%0d got %h want %h", k, obs_pk[k], exp_pk[k]);
            end
        end
        n_chk++;
`ifdef FFT_PEAK_DETECT_EN
        if (obs_pk.size() != 1 || obs_pk[0].m0 !== 32'd9 || obs_pk[0].i0 !== 16'd1) begin
            n_fail++; $display("FAIL frame_peak_9_at_1 got n=%0d mag=%0d idx=%0d want 1/9/1",
                obs_pk.size(), obs_pk.size() ? obs_pk[0].m0 : 0, obs_pk.size() ? obs_pk[0].i0 : 0);
        end
`else
        if (pk_nz != 0 || obs_pk.size() != 0) begin
            n_fail++; $display("FAIL frame_peak_tied_off got nz=%0d pulses=%0d want 0", pk_nz, obs_pk.size());
        end
`endif
    endtask

    task automatic test_gaps();
        logic signed [31:0] r, i;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 8; k++) begin
                idle($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 6) - 3; i = $urandom_range(0, 6) - 3;
                end else begin
                    r = $urandom; i = $urandom;
                end
                drive(r, i, 1'b1, 16'(k));
            end
        end
        idle(6);
        n_chk++;
        if (obs_q.size() != exp_q.size() || side_err != 0) begin
            n_fail++; $display("FAIL gaps beat_count got %0d side_err=%0d want %0d/0", obs_q.size(), side_err, exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            n_chk++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL gaps beat%0d got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        n_chk++;
        if (obs_pk.size() != exp_pk.size()) begin
            n_fail++; $display("FAIL gaps peak_count got %0d want %0d", obs_pk.size(), exp_pk.size());
        end
        foreach (exp_pk[k]) if (k < obs_pk.size()) begin
            n_chk++;
            if (obs_pk[k] !== exp_pk[k]) begin
                n_fail++; $display("FAIL gaps peak%0d got %h want %h", k, obs_pk[k], exp_pk[k]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int k = 0; k < 5; k++) drive($urandom, $urandom, 1'b1, 16'(k));
        #2 rst = 1;
        #1;
        n_chk++;
        if ({mag_out0, mag_valid0, mag_index0, mag_last0, peak_mag0, peak_index0, peak_valid0,
             mag_out1, mag_valid1, peak_mag1, peak_valid1} !== '0) begin
            n_fail++; $display("FAIL async_reset_zero got mag0=%h v0=%b idx0=%0d pk0=%h mag1=%h want 0",
                mag_out0, mag_valid0, mag_index0, peak_mag0, mag_out1);
        end
        clear_all();
        @(negedge clk); valid = 1; index = 16'd7; re = $urandom; im = $urandom;
        @(negedge clk);
        n_chk++;
        if ({mag_valid0, mag_last0, peak_valid0, mag_valid1, peak_valid1} !== '0) begin
            n_fail++; $display("FAIL held_reset_zero got %b want 0",
                {mag_valid0, mag_last0, peak_valid0, mag_valid1, peak_valid1});
        end
        rst = 0; valid = 0;
        for (int k = 0; k < 8; k++) drive($urandom_range(0, 6) - 3, $urandom, 1'b1, 16'(k));
        idle(6);
        n_chk++;
        if (obs_q.size() != exp_q.size() || side_err != 0) begin
            n_fail++; $display("FAIL rst_mid beat_count got %0d side_err=%0d want %0d/0", obs_q.size(), side_err, exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            n_chk++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL rst_mid beat%0d got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        n_chk++;
        if (obs_pk.size() != exp_pk.size()) begin
            n_fail++; $display("FAIL rst_mid peak_count got %0d want %0d", obs_pk.size(), exp_pk.size());
        end
        foreach (exp_pk[k]) if (k < obs_pk.size()) begin
            n_chk++;
            if (obs_pk[k] !== exp_pk[k]) begin
                n_fail++; $display("FAIL rst_mid peak%0d got %h want %h", k, obs_pk[k], exp_pk[k]);
            end
        end
    endtask

    initial begin
        rst = 1; valid = 0; re = 0; im = 0; index = 0;
        test_reset();
        test_magnitude();
        test_frame();
        test_gaps();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
